// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings and helpers for the load/store controller.
package lsu_pkg;

  // Access size encodings (2'b11 is reserved and behaves as a word)
  localparam logic [1:0] LSU_SIZE_B = 2'b00;
  localparam logic [1:0] LSU_SIZE_H = 2'b01;
  localparam logic [1:0] LSU_SIZE_W = 2'b10;

  // Controller states
  typedef enum logic [1:0] {
    LSU_IDLE = 2'b00,
    LSU_REQ  = 2'b01,
    LSU_RESP = 2'b10
  } lsu_state_e;

  // True when an access of this size at this byte offset spills into the next word
  function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic mis;
    case (size)
      LSU_SIZE_B: mis = 1'b0;
      LSU_SIZE_H: mis = (off == 2'd3);
      default:    mis = (off != 2'd0);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// lsu_if: data-memory request/grant/response bus between the LSU and memory.
interface lsu_if;
  logic        data_req_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o;
  logic [31:0] data_wdata_o;
  logic        data_gnt_i;
  logic        data_rvalid_i;
  logic        data_err_i;
  logic [31:0] data_rdata_i;

  modport master (
    output data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
    input  data_gnt_i, data_rvalid_i, data_err_i, data_rdata_i
  );

  modport slave (
    input  data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
    output data_gnt_i, data_rvalid_i, data_err_i, data_rdata_i
  );
endinterface

// File: rtl/lsu_align.sv
// lsu_align: combinational lane logic -- byte enables, write-data shift,
// read-data realignment and sign/zero extension.
// LSU_MISALIGNED_EN adds the second-beat (next word) paths.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] addr_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
`ifdef LSU_MISALIGNED_EN
  input  logic        beat_i,
  input  logic [31:0] rdata_hi_i,
`endif
  input  logic [31:0] rdata_lo_i,
  output logic [3:0]  be_o,
  output logic [31:0] addr_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [1:0]  off;
  logic [3:0]  base_mask;
  logic [31:0] raw_rdata;

  assign off = addr_i[1:0];

  // Unshifted lane mask per access size
  always_comb begin
    base_mask = 4'b1111;
    case (size_i)
      LSU_SIZE_B: base_mask = 4'b0001;
      LSU_SIZE_H: base_mask = 4'b0011;
      default:    base_mask = 4'b1111;
    endcase
  end

`ifdef LSU_MISALIGNED_EN
  logic [7:0] mask8;
  assign mask8     = {4'b0000, base_mask} << off;
  assign be_o      = beat_i ? mask8[7:4] : mask8[3:0];
  // Second beat targets the following word; the increment wraps at the top of memory
  assign addr_o    = beat_i ? {addr_i[31:2] + 30'd1, 2'b00} : {addr_i[31:2], 2'b00};
  assign wdata_o   = beat_i ? (wdata_i >> (6'd32 - {1'b0, off, 3'b000}))
                            : (wdata_i << {off, 3'b000});
  // Shift by 32 at off 0 yields zero, so the high word never leaks into aligned loads
  assign raw_rdata = (rdata_lo_i >> {off, 3'b000})
                   | (rdata_hi_i << (6'd32 - {1'b0, off, 3'b000}));
`else
  assign be_o      = base_mask << off;
  assign addr_o    = {addr_i[31:2], 2'b00};
  assign wdata_o   = wdata_i << {off, 3'b000};
  assign raw_rdata = rdata_lo_i >> {off, 3'b000};
`endif

  // Extend the realigned load from bit 7 or bit 15
  always_comb begin
    rdata_o = raw_rdata;
    case (size_i)
      LSU_SIZE_B: rdata_o = {{24{~unsigned_i & raw_rdata[7]}}, raw_rdata[7:0]};
      LSU_SIZE_H: rdata_o = {{16{~unsigned_i & raw_rdata[15]}}, raw_rdata[15:0]};
      default:    rdata_o = raw_rdata;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store controller FSM between execute and the data-memory bus.
// Optional feature macro: LSU_MISALIGNED_EN (split word-crossing accesses into
// two bus beats; when undefined such accesses complete at once with an error).
module lsu_ctrl
  import lsu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        i_exe_wmem,
  input  logic        i_exe_mem2reg,
  input  logic [1:0]  i_exe_size,
  input  logic        i_exe_unsigned,
  input  logic [31:0] i_data_addr,
  input  logic [31:0] i_data_wdata,
  output logic        o_lsu_busy,
  output logic        o_lsu_done,
  output logic        o_lsu_err,
  output logic [31:0] o_data_rdata,
  lsu_if.master       bus
);

  lsu_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
`ifdef LSU_MISALIGNED_EN
  logic        beat_q, beat_d;
  logic [31:0] rdata0_q, rdata0_d;
`endif

  logic        accept;
  logic        req;
  logic [3:0]  al_be;
  logic [31:0] al_addr, al_wdata, al_rdata;

  assign accept     = (i_exe_wmem | i_exe_mem2reg) & (state_q == LSU_IDLE) & ~done_q;
  assign o_lsu_busy = (state_q != LSU_IDLE) | accept;
  assign o_lsu_done = done_q;
  assign o_lsu_err  = err_q;
  assign o_data_rdata = rdata_q;

  // Bus outputs come from registered fields only, so they hold steady while waiting for grant
  assign req              = (state_q == LSU_REQ);
  assign bus.data_req_o   = req;
  assign bus.data_we_o    = req & we_q;
  assign bus.data_be_o    = req ? al_be : 4'b0000;
  assign bus.data_addr_o  = req ? al_addr : 32'd0;
  assign bus.data_wdata_o = req ? al_wdata : 32'd0;

  lsu_align u_align (
    .addr_i     (addr_q),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .wdata_i    (wdata_q),
`ifdef LSU_MISALIGNED_EN
    .beat_i     (beat_q),
    .rdata_hi_i (beat_q ? bus.data_rdata_i : 32'd0),
    .rdata_lo_i (beat_q ? rdata0_q : bus.data_rdata_i),
`else
    .rdata_lo_i (bus.data_rdata_i),
`endif
    .be_o       (al_be),
    .addr_o     (al_addr),
    .wdata_o    (al_wdata),
    .rdata_o    (al_rdata)
  );

  // Next-state and capture logic for accept, grant and response
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    uns_d   = uns_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
`ifdef LSU_MISALIGNED_EN
    beat_d   = beat_q;
    rdata0_d = rdata0_q;
`endif
    case (state_q)
      LSU_IDLE: begin
        if (accept) begin
          addr_d  = i_data_addr;
          size_d  = i_exe_size;
          uns_d   = i_exe_unsigned;
          wdata_d = i_data_wdata;
          we_d    = i_exe_wmem;  // store wins when both requests are raised
          state_d = LSU_REQ;
`ifdef LSU_MISALIGNED_EN
          beat_d  = 1'b0;
`else
          // Word-crossing access cannot be served: finish immediately with an error
          if (lsu_misaligned(i_exe_size, i_data_addr[1:0])) begin
            state_d = LSU_IDLE;
            done_d  = 1'b1;
            err_d   = 1'b1;
            rdata_d = 32'd0;
          end
`endif
        end
      end
      LSU_REQ: begin
        if (bus.data_gnt_i) state_d = LSU_RESP;
      end
      LSU_RESP: begin
        if (bus.data_rvalid_i) begin
          // A second beat only follows an error-free first beat, so this
          // final error is already the OR over all beats
          state_d = LSU_IDLE;
          done_d  = 1'b1;
          err_d   = bus.data_err_i;
          rdata_d = we_q ? 32'd0 : al_rdata;
`ifdef LSU_MISALIGNED_EN
          if (!beat_q && lsu_misaligned(size_q, addr_q[1:0]) && !bus.data_err_i) begin
            state_d  = LSU_REQ;
            done_d   = 1'b0;
            err_d    = 1'b0;
            rdata_d  = rdata_q;
            rdata0_d = bus.data_rdata_i;
            beat_d   = 1'b1;
          end
`endif
        end
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  // State and access registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= LSU_IDLE;
      addr_q   <= 32'd0;
      size_q   <= LSU_SIZE_B;
      uns_q    <= 1'b0;
      wdata_q  <= 32'd0;
      we_q     <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= 32'd0;
`ifdef LSU_MISALIGNED_EN
      beat_q   <= 1'b0;
      rdata0_q <= 32'd0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      uns_q    <= uns_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
`ifdef LSU_MISALIGNED_EN
      beat_q   <= beat_d;
      rdata0_q <= rdata0_d;
`endif
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed scoreboard bench for lsu_ctrl (both LSU_MISALIGNED_EN builds).
module tb_lsu_ctrl;
  import lsu_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        i_exe_wmem = 1'b0;
  logic        i_exe_mem2reg = 1'b0;
  logic [1:0]  i_exe_size = 2'b00;
  logic        i_exe_unsigned = 1'b0;
  logic [31:0] i_data_addr = 32'd0;
  logic [31:0] i_data_wdata = 32'd0;
  logic        o_lsu_busy, o_lsu_done, o_lsu_err;
  logic [31:0] o_data_rdata;

  lsu_if bus ();

  lsu_ctrl dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .i_exe_wmem     (i_exe_wmem),
    .i_exe_mem2reg  (i_exe_mem2reg),
    .i_exe_size     (i_exe_size),
    .i_exe_unsigned (i_exe_unsigned),
    .i_data_addr    (i_data_addr),
    .i_data_wdata   (i_data_wdata),
    .o_lsu_busy     (o_lsu_busy),
    .o_lsu_done     (o_lsu_done),
    .o_lsu_err      (o_lsu_err),
    .o_data_rdata   (o_data_rdata),
    .bus            (bus)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       tag;
    logic        err;
    logic        chk_rd;
    logic [31:0] rd;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Present one access for a single cycle (accept at the next edge); push the expected result
  task automatic issue(input string tag, input logic wr, input logic rd, input logic [1:0] size,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic push, input logic exp_err, input logic chk_rd,
                       input logic [31:0] exp_rd);
    exp_t e;
    i_exe_wmem = wr; i_exe_mem2reg = rd; i_exe_size = size;
    i_exe_unsigned = uns; i_data_addr = addr; i_data_wdata = wdata;
    if (push) begin
      e.tag = tag; e.err = exp_err; e.chk_rd = chk_rd; e.rd = exp_rd;
      sb_q.push_back(e);
    end
    #1;
    chk1({tag, " busy@T0"}, o_lsu_busy, 1'b1);
    @(negedge clk_i);
    i_exe_wmem = 1'b0; i_exe_mem2reg = 1'b0;
    $display("issue %s wr=%b size=%0d addr=%h wdata=%h", tag, wr, size, addr, wdata);
  endtask

  // Serve one bus beat starting at a negedge where the request should be up
  task automatic beat(input string tag, input int gnt_wait, input logic stray_rv,
                      input logic exp_we, input logic [3:0] exp_be, input logic [31:0] exp_addr,
                      input logic [31:0] exp_wd, input logic [31:0] wd_mask, input int rv_wait,
                      input logic [31:0] rdata, input logic err);
    chk1({tag, " req"}, bus.data_req_o, 1'b1);
    chk1({tag, " we"}, bus.data_we_o, exp_we);
    chk32({tag, " be"}, 32'(bus.data_be_o), 32'(exp_be));
    chk32({tag, " addr"}, bus.data_addr_o, exp_addr);
    if (exp_we) chk32({tag, " wdata"}, bus.data_wdata_o & wd_mask, exp_wd);
    for (int i = 0; i < gnt_wait; i++) begin
      if (stray_rv && i == 0) begin
        bus.data_rvalid_i = 1'b1; bus.data_rdata_i = 32'hBAD0BAD0;
      end
      @(negedge clk_i);
      bus.data_rvalid_i = 1'b0;
      chk1({tag, " req held"}, bus.data_req_o, 1'b1);
      chk32({tag, " be held"}, 32'(bus.data_be_o), 32'(exp_be));
      chk32({tag, " addr held"}, bus.data_addr_o, exp_addr);
    end
    bus.data_gnt_i = 1'b1;
    @(negedge clk_i);
    bus.data_gnt_i = 1'b0;
    chk1({tag, " req dropped"}, bus.data_req_o, 1'b0);
    for (int i = 0; i < rv_wait; i++) begin
      @(negedge clk_i);
      chk1({tag, " no early done"}, o_lsu_done, 1'b0);
    end
    bus.data_rvalid_i = 1'b1; bus.data_rdata_i = rdata; bus.data_err_i = err;
    @(negedge clk_i);
    bus.data_rvalid_i = 1'b0; bus.data_err_i = 1'b0; bus.data_rdata_i = 32'd0;
    $display("beat %s be=%b addr=%h rdata=%h err=%b", tag, exp_be, exp_addr, rdata, err);
  endtask

  // Completion must be visible right now, for exactly one cycle
  task automatic finish_access();
    exp_t e;
    chk1("done", o_lsu_done, 1'b1);
    chk1("busy@done", o_lsu_busy, 1'b0);
    chk1("no req@done", bus.data_req_o, 1'b0);
    if (sb_q.size() == 0) begin
      chk1("scoreboard empty", 1'b1, 1'b0);
    end else begin
      e = sb_q.pop_front();
      chk1({e.tag, " err"}, o_lsu_err, e.err);
      if (e.chk_rd) chk32({e.tag, " rdata"}, o_data_rdata, e.rd);
      $display("done %s err=%b rdata=%h", e.tag, o_lsu_err, o_data_rdata);
    end
    @(negedge clk_i);
    chk1("done pulse", o_lsu_done, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.data_gnt_i = 1'b0; bus.data_rvalid_i = 1'b0;
    bus.data_err_i = 1'b0; bus.data_rdata_i = 32'd0;
    repeat (3) @(negedge clk_i);
    chk1("rst req", bus.data_req_o, 1'b0);
    chk32("rst be", 32'(bus.data_be_o), 32'd0);
    chk1("rst done", o_lsu_done, 1'b0);
    chk32("rst rdata", o_data_rdata, 32'd0);
    chk1("rst busy", o_lsu_busy, 1'b0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Aligned word store with a two-cycle grant wait
    issue("sw 100", 1, 0, LSU_SIZE_W, 0, 32'h100, 32'hDEADBEEF, 1, 0, 0, 32'd0);
    beat("sw 100", 2, 0, 1, 4'b1111, 32'h100, 32'hDEADBEEF, 32'hFFFFFFFF, 0, 32'd0, 0);
    finish_access();

    // Byte loads at offset 3, signed then unsigned
    issue("lb 203", 0, 1, LSU_SIZE_B, 0, 32'h203, 32'd0, 1, 0, 1, 32'hFFFFFF80);
    beat("lb 203", 0, 0, 0, 4'b1000, 32'h200, 32'd0, 32'd0, 0, 32'h80123456, 0);
    finish_access();
    issue("lbu 203", 0, 1, LSU_SIZE_B, 1, 32'h203, 32'd0, 1, 0, 1, 32'h00000080);
    beat("lbu 203", 0, 0, 0, 4'b1000, 32'h200, 32'd0, 32'd0, 0, 32'h80123456, 0);
    finish_access();

    // Half store with both requests raised: must be a store
    issue("sh 102", 1, 1, LSU_SIZE_H, 0, 32'h102, 32'h00001234, 1, 0, 0, 32'd0);
    beat("sh 102", 0, 0, 1, 4'b1100, 32'h100, 32'h12340000, 32'hFFFF0000, 0, 32'd0, 0);
    finish_access();

    // Signed half load with a stray rvalid in REQ and two response wait cycles
    issue("lh 102", 0, 1, LSU_SIZE_H, 0, 32'h102, 32'd0, 1, 0, 1, 32'hFFFF8001);
    beat("lh 102", 1, 1, 0, 4'b1100, 32'h100, 32'd0, 32'd0, 2, 32'h80015555, 0);
    finish_access();

    // Aligned word load
    issue("lw 300", 0, 1, LSU_SIZE_W, 0, 32'h300, 32'd0, 1, 0, 1, 32'hCAFEF00D);
    beat("lw 300", 0, 0, 0, 4'b1111, 32'h300, 32'd0, 32'd0, 0, 32'hCAFEF00D, 0);
    finish_access();

`ifdef LSU_MISALIGNED_EN
    issue("lw 101", 0, 1, LSU_SIZE_W, 0, 32'h101, 32'd0, 1, 0, 1, 32'h44332211);
    beat("lw 101 b0", 0, 0, 0, 4'b1110, 32'h100, 32'd0, 32'd0, 0, 32'h332211AA, 0);
    beat("lw 101 b1", 0, 0, 0, 4'b0001, 32'h104, 32'd0, 32'd0, 0, 32'h55555544, 0);
    finish_access();

    issue("sh 103", 1, 0, LSU_SIZE_H, 0, 32'h103, 32'h0000ABCD, 1, 0, 0, 32'd0);
    beat("sh 103 b0", 0, 0, 1, 4'b1000, 32'h100, 32'hCD000000, 32'hFF000000, 0, 32'd0, 0);
    beat("sh 103 b1", 0, 0, 1, 4'b0001, 32'h104, 32'h000000AB, 32'h000000FF, 0, 32'd0, 0);
    finish_access();

    issue("lhu wrap", 0, 1, LSU_SIZE_H, 1, 32'hFFFFFFFF, 32'd0, 1, 0, 1, 32'h0000E17F);
    beat("lhu wrap b0", 0, 0, 0, 4'b1000, 32'hFFFFFFFC, 32'd0, 32'd0, 0, 32'h7F000000, 0);
    beat("lhu wrap b1", 0, 0, 0, 4'b0001, 32'h00000000, 32'd0, 32'd0, 0, 32'h000000E1, 0);
    finish_access();

    // Error on the first beat cancels the second
    issue("sw 102 err", 1, 0, LSU_SIZE_W, 0, 32'h102, 32'h11223344, 1, 1, 0, 32'd0);
    beat("sw 102 err b0", 0, 0, 1, 4'b1100, 32'h100, 32'h33440000, 32'hFFFF0000, 0, 32'd0, 1);
    finish_access();
`else
    // Misaligned accesses finish at T1 with an error and no bus request
    issue("lw 101 mis", 0, 1, LSU_SIZE_W, 0, 32'h101, 32'd0, 1, 1, 1, 32'd0);
    finish_access();
    issue("sh 103 mis", 1, 0, LSU_SIZE_H, 0, 32'h103, 32'h0000ABCD, 1, 1, 1, 32'd0);
    finish_access();
`endif

    // Bus error on an aligned load
    issue("lw 204 err", 0, 1, LSU_SIZE_W, 0, 32'h204, 32'd0, 1, 1, 0, 32'd0);
    beat("lw 204 err", 0, 0, 0, 4'b1111, 32'h204, 32'd0, 32'd0, 0, 32'h0, 1);
    finish_access();

    // Reset while in RESP; late response must not complete anything
    issue("lw 400 rst", 0, 1, LSU_SIZE_W, 0, 32'h400, 32'd0, 0, 0, 0, 32'd0);
    chk1("rst-case req", bus.data_req_o, 1'b1);
    bus.data_gnt_i = 1'b1;
    @(negedge clk_i);
    bus.data_gnt_i = 1'b0;
    rst_ni = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    chk1("post-rst req", bus.data_req_o, 1'b0);
    chk1("post-rst busy", o_lsu_busy, 1'b0);
    bus.data_rvalid_i = 1'b1; bus.data_rdata_i = 32'h99999999;
    @(negedge clk_i);
    bus.data_rvalid_i = 1'b0; bus.data_rdata_i = 32'd0;
    chk1("late rvalid no done", o_lsu_done, 1'b0);
    @(negedge clk_i);
    chk1("late rvalid no done+1", o_lsu_done, 1'b0);
    $display("reset-in-RESP sequence complete");

    // Recovery after reset
    issue("lw 500", 0, 1, LSU_SIZE_W, 0, 32'h500, 32'd0, 1, 0, 1, 32'h12345678);
    beat("lw 500", 0, 0, 0, 4'b1111, 32'h500, 32'd0, 32'd0, 0, 32'h12345678, 0);
    finish_access();

    chk32("scoreboard drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
